etapa_escritura: RTL and testbench
==================================

// Module: etapa_escritura
// PURPOSE
// - MEM/WB pipeline register plus write-back stage of the 32-bit MIPS-style datapath.
// - Latches the memory-stage result bundle and selects the write-back source.
// - Drives datoesc/diresc/enesc into the register-file write port.
// - Provides write-to-read bypass hits for the register-file read addresses.
// - Keeps a retired-instruction counter.
// PARAMETERS
// ANCHO   32  data path width (bits)
// DIR     5   register address width (bits)
// PORTS
// clk          in   1      clock; all state updates on rising edge
// rst          in   1      synchronous reset, active-high
// ent_valido   in   1      upstream bundle valid this cycle
// ent_listo    out  1      stage accepts bundle this cycle (= ~detener)
// detener      in   1      stall from hazard unit; blocks acceptance
// vaciar       in   1      flush; discards incoming bundle
// ent_resalu   in   ANCHO  ALU result
// ent_datomem  in   ANCHO  data-memory read value
// ent_pc4      in   ANCHO  PC+4 (link value)
// ent_inm      in   ANCHO  upper-immediate value (LUI)
// ent_selwb    in   2      source select: 00 alu, 01 mem, 10 pc4, 11 inm
// ent_regesc   in   1      instruction writes a register
// ent_diresc   in   DIR    destination register
// dirlec1      in   DIR    register-file read address 1 (bypass compare)
// dirlec2      in   DIR    register-file read address 2 (bypass compare)
// datoesc      out  ANCHO  write data to register file
// diresc       out  DIR    write address to register file
// enesc        out  1      write enable to register file
// usa_fwd1     out  1      datoesc must replace datolec1 this cycle
// usa_fwd2     out  1      datoesc must replace datolec2 this cycle
// cnt_retiro   out  32     retired-instruction count
// BEHAVIOUR
// - Reset (rst=1 at edge): v_q=0, all bundle regs=0, cnt_retiro=0.
//   Therefore datoesc=0, diresc=0, enesc=0, usa_fwd1=0, usa_fwd2=0.
// - Reset mid-operation drops any pending write; no enesc in the following cycle.
// - Acceptance: carga = ent_valido & ~detener; ent_listo = ~detener (combinational).
// - Edge update, priority order rst > vaciar > carga:
//   vaciar=1: v_q<=0; bundle discarded; still counts as consumed if ent_listo=1.
//   carga=1 (no vaciar): v_q<=1; latch resalu, datomem, pc4, inm, selwb, regesc, diresc.
//   otherwise: v_q<=0; data regs hold (don't care).
// - Latency: accepted at edge N -> enesc high during cycle N+1, for exactly one cycle.
//   No repeated write while detener stays high.
// - enesc  = v_q & regesc_q & (diresc_q != 0); writes to register 0 never issued.
// - datoesc = mux(selwb_q) of registered values; combinational from regs only.
//   No input-to-output combinational path except ent_listo and usa_fwd*.
// - diresc = diresc_q.
// - usa_fwdK = enesc & (diresc == dirlecK), K=1,2; both may be high simultaneously.
// - cnt_retiro increments by 1 at every edge where v_q=1, whether or not a write occurs.
//   Wraps 0xFFFFFFFF -> 0; flush bubbles are not counted.
// - Simultaneous vaciar & detener: nothing accepted, v_q<=0.
// TESTING
// - Reset: rst=1 two cycles with ent_valido=1 -> enesc=0, cnt_retiro=0, datoesc=0
//   during reset and on the first cycle after.
// - ALU write: resalu=0x0000_00A5, selwb=00, regesc=1, diresc=7, accepted at edge N
//   -> cycle N+1: enesc=1, diresc=7, datoesc=0xA5; cycle N+2: enesc=0.
// - Source mux: selwb=01/10/11 with datomem=0x11, pc4=0x400, inm=0xBEEF0000
//   -> datoesc=0x11, 0x400, 0xBEEF0000 respectively.
// - Reg 0 and flush: diresc=0, regesc=1 -> enesc=0 and cnt increments.
//   vaciar=1 with valid bundle -> enesc=0 and cnt unchanged.
// - Stall: detener=1 for 3 cycles with ent_valido=1 -> ent_listo=0, no enesc pulses.
//   Release -> single enesc pulse one cycle later.
// - Bypass/wrap: write to r5 with dirlec1=5, dirlec2=5 -> usa_fwd1=usa_fwd2=1.
//   Preload cnt=0xFFFFFFFF via 2^32-1 retirements or force -> next retire gives 0.

Source files
------------

// File: rtl/etapa_escritura.sv
// MEM/WB pipeline register and write-back stage: latches the memory-stage bundle,
// selects the write-back source, flags register-file bypass hits and counts retirements.
module etapa_escritura #(
  parameter int unsigned ANCHO = 32,
  parameter int unsigned DIR   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ent_valido,
  output logic             ent_listo,
  input  logic             detener,
  input  logic             vaciar,
  input  logic [ANCHO-1:0] ent_resalu,
  input  logic [ANCHO-1:0] ent_datomem,
  input  logic [ANCHO-1:0] ent_pc4,
  input  logic [ANCHO-1:0] ent_inm,
  input  logic [1:0]       ent_selwb,
  input  logic             ent_regesc,
  input  logic [DIR-1:0]   ent_diresc,
  input  logic [DIR-1:0]   dirlec1,
  input  logic [DIR-1:0]   dirlec2,
  output logic [ANCHO-1:0] datoesc,
  output logic [DIR-1:0]   diresc,
  output logic             enesc,
  output logic             usa_fwd1,
  output logic             usa_fwd2,
  output logic [31:0]      cnt_retiro
);

  logic             carga;
  logic             v_q;
  logic [ANCHO-1:0] resalu_q;
  logic [ANCHO-1:0] datomem_q;
  logic [ANCHO-1:0] pc4_q;
  logic [ANCHO-1:0] inm_q;
  logic [1:0]       selwb_q;
  logic             regesc_q;
  logic [DIR-1:0]   diresc_q;
  logic [31:0]      cnt_q;

  assign ent_listo = ~detener;
  assign carga     = ent_valido & ~detener;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q       <= 1'b0;
      resalu_q  <= '0;
      datomem_q <= '0;
      pc4_q     <= '0;
      inm_q     <= '0;
      selwb_q   <= 2'b00;
      regesc_q  <= 1'b0;
      diresc_q  <= '0;
      cnt_q     <= '0;
    end else begin
      // A flushed bundle leaves the data registers untouched; only v_q matters.
      v_q <= carga & ~vaciar;
      if (carga && !vaciar) begin
        resalu_q  <= ent_resalu;
        datomem_q <= ent_datomem;
        pc4_q     <= ent_pc4;
        inm_q     <= ent_inm;
        selwb_q   <= ent_selwb;
        regesc_q  <= ent_regesc;
        diresc_q  <= ent_diresc;
      end
      if (v_q) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  always_comb begin
    datoesc = resalu_q;
    unique case (selwb_q)
      2'b00:   datoesc = resalu_q;
      2'b01:   datoesc = datomem_q;
      2'b10:   datoesc = pc4_q;
      2'b11:   datoesc = inm_q;
      default: datoesc = resalu_q;
    endcase
  end

  assign diresc     = diresc_q;
  assign enesc      = v_q & regesc_q & (diresc_q != '0);
  assign usa_fwd1   = enesc & (diresc_q == dirlec1);
  assign usa_fwd2   = enesc & (diresc_q == dirlec2);
  assign cnt_retiro = cnt_q;

endmodule

// File: tb/tb_etapa_escritura.sv
// Directed plus randomized bench for etapa_escritura against a bundle-level reference model.
module tb_etapa_escritura;

  logic        clk = 1'b0;
  logic        rst, ent_valido, detener, vaciar, ent_regesc;
  logic        ent_listo, enesc, usa_fwd1, usa_fwd2;
  logic [31:0] ent_resalu, ent_datomem, ent_pc4, ent_inm, datoesc, cnt_retiro;
  logic [1:0]  ent_selwb;
  logic [4:0]  ent_diresc, dirlec1, dirlec2, diresc;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Reference model: the bundle most recently accepted, whether it is live, retire count.
  logic        m_live;
  logic [31:0] m_src [4];
  logic [1:0]  m_sel;
  logic        m_we;
  logic [4:0]  m_dir;
  logic [31:0] m_cnt;

  etapa_escritura #(.ANCHO(32), .DIR(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .ent_valido (ent_valido),
    .ent_listo  (ent_listo),
    .detener    (detener),
    .vaciar     (vaciar),
    .ent_resalu (ent_resalu),
    .ent_datomem(ent_datomem),
    .ent_pc4    (ent_pc4),
    .ent_inm    (ent_inm),
    .ent_selwb  (ent_selwb),
    .ent_regesc (ent_regesc),
    .ent_diresc (ent_diresc),
    .dirlec1    (dirlec1),
    .dirlec2    (dirlec2),
    .datoesc    (datoesc),
    .diresc     (diresc),
    .enesc      (enesc),
    .usa_fwd1   (usa_fwd1),
    .usa_fwd2   (usa_fwd2),
    .cnt_retiro (cnt_retiro)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    logic        e_en;
    logic [31:0] e_dat;
    e_en  = m_live && m_we && (m_dir != 5'd0);
    e_dat = m_src[m_sel];
    check("enesc", {31'd0, enesc}, {31'd0, e_en});
    check("datoesc", datoesc, e_dat);
    check("diresc", {27'd0, diresc}, {27'd0, m_dir});
    check("usa_fwd1", {31'd0, usa_fwd1}, {31'd0, e_en && (m_dir == dirlec1)});
    check("usa_fwd2", {31'd0, usa_fwd2}, {31'd0, e_en && (m_dir == dirlec2)});
    check("cnt_retiro", cnt_retiro, m_cnt);
  endtask

  // Inputs are already applied; check ent_listo, clock once, advance model, check outputs.
  task automatic tick();
    #1;
    check("ent_listo", {31'd0, ent_listo}, {31'd0, !detener});
    @(posedge clk);
    if (rst) begin
      m_live = 1'b0;
      m_cnt  = 32'd0;
      for (int i = 0; i < 4; i++) m_src[i] = 32'd0;
      m_sel = 2'd0;
      m_we  = 1'b0;
      m_dir = 5'd0;
    end else begin
      if (m_live) m_cnt = m_cnt + 32'd1;
      m_live = ent_valido && !detener && !vaciar;
      if (m_live) begin
        m_src[0] = ent_resalu;
        m_src[1] = ent_datomem;
        m_src[2] = ent_pc4;
        m_src[3] = ent_inm;
        m_sel    = ent_selwb;
        m_we     = ent_regesc;
        m_dir    = ent_diresc;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic bundle(input logic v, input logic [1:0] sel, input logic we,
                        input logic [4:0] dir);
    ent_valido  = v;
    ent_selwb   = sel;
    ent_regesc  = we;
    ent_diresc  = dir;
    ent_resalu  = 32'h0000_00A5;
    ent_datomem = 32'h0000_0011;
    ent_pc4     = 32'h0000_0400;
    ent_inm     = 32'hBEEF_0000;
  endtask

  initial begin
    m_live = 1'b0;
    m_cnt  = 32'd0;
    for (int i = 0; i < 4; i++) m_src[i] = 32'd0;
    m_sel = 2'd0;
    m_we  = 1'b0;
    m_dir = 5'd0;

    // Reset held two cycles with a valid bundle offered.
    rst = 1'b1; detener = 1'b0; vaciar = 1'b0; dirlec1 = 5'd7; dirlec2 = 5'd0;
    bundle(1'b1, 2'b00, 1'b1, 5'd7);
    tick();
    tick();
    rst = 1'b0;
    bundle(1'b0, 2'b00, 1'b0, 5'd0);
    tick();
    check("reset_enesc", {31'd0, enesc}, 32'd0);
    check("reset_cnt", cnt_retiro, 32'd0);
    check("reset_dato", datoesc, 32'd0);

    // ALU write to r7, then the pulse ends.
    bundle(1'b1, 2'b00, 1'b1, 5'd7);
    tick();
    check("alu_data", datoesc, 32'h0000_00A5);
    check("alu_en", {31'd0, enesc}, 32'd1);
    bundle(1'b0, 2'b00, 1'b0, 5'd0);
    tick();
    check("alu_pulse_end", {31'd0, enesc}, 32'd0);

    // Source mux over mem, pc4 and immediate.
    bundle(1'b1, 2'b01, 1'b1, 5'd3); tick(); check("mux_mem", datoesc, 32'h0000_0011);
    bundle(1'b1, 2'b10, 1'b1, 5'd31); tick(); check("mux_pc4", datoesc, 32'h0000_0400);
    bundle(1'b1, 2'b11, 1'b1, 5'd9); tick(); check("mux_inm", datoesc, 32'hBEEF_0000);

    // Write to r0 is suppressed but still retires; a flushed bundle does neither.
    bundle(1'b1, 2'b00, 1'b1, 5'd0); tick(); check("r0_no_write", {31'd0, enesc}, 32'd0);
    vaciar = 1'b1; bundle(1'b1, 2'b00, 1'b1, 5'd4); tick(); vaciar = 1'b0;
    bundle(1'b0, 2'b00, 1'b0, 5'd0); tick();
    check("flush_no_write", {31'd0, enesc}, 32'd0);
    tick();

    // Stall for three cycles, then release into a single pulse.
    detener = 1'b1; bundle(1'b1, 2'b00, 1'b1, 5'd12);
    for (int i = 0; i < 3; i++) tick();
    detener = 1'b0; tick();
    check("stall_release_en", {31'd0, enesc}, 32'd1);
    bundle(1'b0, 2'b00, 1'b0, 5'd0); tick();

    // Flush and stall together accept nothing.
    vaciar = 1'b1; detener = 1'b1; bundle(1'b1, 2'b00, 1'b1, 5'd6); tick();
    vaciar = 1'b0; detener = 1'b0; bundle(1'b0, 2'b00, 1'b0, 5'd0); tick();

    // Double bypass hit on r5.
    dirlec1 = 5'd5; dirlec2 = 5'd5; bundle(1'b1, 2'b00, 1'b1, 5'd5); tick();
    check("fwd_both", {30'd0, usa_fwd1, usa_fwd2}, 32'd3);
    bundle(1'b0, 2'b00, 1'b0, 5'd0); tick();

    // Counter wrap via a forced preload while no bundle is live.
    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    bundle(1'b1, 2'b00, 1'b0, 5'd2); tick();
    check("wrap_pre", cnt_retiro, 32'hFFFF_FFFF);
    bundle(1'b0, 2'b00, 1'b0, 5'd0); tick();
    check("wrap_zero", cnt_retiro, 32'd0);

    // Randomized traffic, with an occasional mid-stream reset.
    for (int i = 0; i < 300; i++) begin
      rst         = ($urandom_range(0, 49) == 0);
      ent_valido  = ($urandom_range(0, 3) != 0);
      detener     = ($urandom_range(0, 4) == 0);
      vaciar      = ($urandom_range(0, 6) == 0);
      ent_resalu  = $urandom;
      ent_datomem = $urandom;
      ent_pc4     = $urandom;
      ent_inm     = $urandom;
      ent_selwb   = 2'($urandom_range(0, 3));
      ent_regesc  = ($urandom_range(0, 3) != 0);
      ent_diresc  = 5'($urandom_range(0, 7));
      dirlec1     = 5'($urandom_range(0, 7));
      dirlec2     = 5'($urandom_range(0, 7));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
